// File: rtl/dmem_timer_bus.sv
// Data-side memory stage: word-addressed data RAM plus a memory-mapped countdown timer with interrupt.
// Optional macro TIMER_PRESCALE_EN adds the PRESC register (offset 0x10) and a timer prescaler.
module dmem_timer_bus #(
    parameter int          DM_DEPTH   = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [31:0] count_dbg
);
    localparam int          AW        = $clog2(DM_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DM_DEPTH * 4);
`ifdef TIMER_PRESCALE_EN
    localparam int          TLSB      = 5;
    localparam logic [2:0]  OFF_PRESC = 3'd4;
`else
    localparam int          TLSB      = 4;
`endif
    localparam logic [2:0]  OFF_CTRL   = 3'd0;
    localparam logic [2:0]  OFF_PRESET = 3'd1;
    localparam logic [2:0]  OFF_COUNT  = 3'd2;
    localparam logic [2:0]  OFF_STATUS = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } tstate_e;

    logic [31:0] mem_q [DM_DEPTH];
    logic [2:0]  ctrl_q, ctrl_d, ctrl_w_s;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;
    logic        irq_q, irq_d;
    tstate_e     state_q, state_d;
    logic        ram_hit_s, tmr_hit_s, step_s;
    logic [2:0]  toff_s;
    logic [AW-1:0] widx_s;
    logic        wr_ctrl_s, wr_preset_s, wr_status_s;
    logic        unused_s;
`ifdef TIMER_PRESCALE_EN
    logic [31:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic        wr_presc_s;
`endif

    assign ram_hit_s   = (addr < RAM_BYTES);
    assign tmr_hit_s   = (addr[31:TLSB] == TIMER_BASE[31:TLSB]);
    assign widx_s      = addr[AW+1:2];
    assign unused_s    = ^addr[1:0];
`ifdef TIMER_PRESCALE_EN
    assign toff_s      = addr[4:2];
    assign wr_presc_s  = we && tmr_hit_s && (toff_s == OFF_PRESC);
    assign step_s      = (pcnt_q == presc_q);
`else
    assign toff_s      = {1'b0, addr[3:2]};
    assign step_s      = 1'b1;
`endif
    assign wr_ctrl_s   = we && tmr_hit_s && (toff_s == OFF_CTRL);
    assign wr_preset_s = we && tmr_hit_s && (toff_s == OFF_PRESET);
    assign wr_status_s = we && tmr_hit_s && (toff_s == OFF_STATUS);
    // A CPU write to CTRL is seen by the timer in the same cycle it is issued.
    assign ctrl_w_s    = wr_ctrl_s ? wdata[2:0] : ctrl_q;

    assign irq       = irq_q;
    assign count_dbg = count_q;

    // Data RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && ram_hit_s) begin
            mem_q[widx_s] <= wdata;
        end
    end

    // Combinational load-data mux.
    always_comb begin
        rdata = 32'h0;
        if (tmr_hit_s) begin
            case (toff_s)
                OFF_CTRL:   rdata = {29'h0, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
                OFF_STATUS: rdata = {31'h0, pend_q};
`ifdef TIMER_PRESCALE_EN
                OFF_PRESC:  rdata = presc_q;
`endif
                default:    rdata = 32'h0;
            endcase
        end else if (ram_hit_s) begin
            rdata = mem_q[widx_s];
        end else begin
            rdata = 32'h0;
        end
    end

    // Timer next-state: register writes, countdown FSM, pending flag and interrupt.
    always_comb begin
        ctrl_d   = ctrl_w_s;
        preset_d = wr_preset_s ? wdata : preset_q;
        count_d  = count_q;
        state_d  = state_q;
        pend_d   = (wr_status_s && wdata[0]) ? 1'b0 : pend_q;
`ifdef TIMER_PRESCALE_EN
        presc_d  = wr_presc_s ? wdata : presc_q;
        pcnt_d   = pcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef TIMER_PRESCALE_EN
                pcnt_d = 32'h0;
`endif
                state_d = ctrl_w_s[0] ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
`ifdef TIMER_PRESCALE_EN
                pcnt_d = 32'h0;
`endif
                count_d = preset_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!ctrl_w_s[0]) begin
                    state_d = ST_IDLE;
                end else if (step_s) begin
`ifdef TIMER_PRESCALE_EN
                    pcnt_d = 32'h0;
`endif
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // Terminal count: setting PEND overrides a same-cycle W1C.
                        count_d = 32'h0;
                        pend_d  = 1'b1;
                        if (ctrl_w_s[1]) begin
                            state_d = ST_LOAD;
                        end else begin
                            ctrl_d[0] = 1'b0;
                            state_d   = ST_IDLE;
                        end
                    end
                end else begin
`ifdef TIMER_PRESCALE_EN
                    pcnt_d = pcnt_q + 32'd1;
`endif
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = pend_d & ctrl_d[2];
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= 3'h0;
            preset_q <= 32'h0;
            count_q  <= 32'h0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            state_q  <= ST_IDLE;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= 32'h0;
            pcnt_q   <= 32'h0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            state_q  <= state_d;
`ifdef TIMER_PRESCALE_EN
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
`endif
        end
    end
endmodule
